jbi_mout_sched: RTL and testbench

JBI_MOUT_SCHED -- requirements
Module: jbi_mout_sched

---
 rtl/jbi_mout_sched_pkg.sv | 10 +
 rtl/jbi_mout_sched_if.sv | 29 ++
 rtl/jbi_rr_pick4.sv | 17 +
 rtl/jbi_mout_sched.sv | 80 ++++++++
 tb/tb_jbi_mout_sched.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/jbi_mout_sched_pkg.sv
// jbi_mout_sched_pkg: shared states, requester ids and helpers for the JBus mout scheduler
package jbi_mout_sched_pkg;
    localparam int N_REQ = 4;
    localparam logic [1:0] REQ_PIORQQ = 2'd0;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SEND} state_e;
    function automatic logic [1:0] oh2bin(input logic [N_REQ-1:0] oh);
        oh2bin = '0;
        for (int i = 0; i < N_REQ; i++) if (oh[i]) oh2bin = i[1:0];
    endfunction
endpackage

// File: rtl/jbi_mout_sched_if.sv
// jbi_mout_sched_if: requester/arbiter inputs and beat/scheduling outputs of the mout scheduler
interface jbi_mout_sched_if;
    import jbi_mout_sched_pkg::*;
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] req_len;
    logic [N_REQ-1:0]   flow_ok;
    logic               multiple_ok;
    logic               parked_on_us;
    logic               int_req;
    logic               multiple_in_progress;
    logic               stream_break_point;
    logic               int_requestor_piorqq;
    logic               have_trans_waiting;
    logic               piorqq_req;
    logic [N_REQ-1:0]   sel;
    logic               beat_vld;
    logic               beat_last;
    logic [N_REQ-1:0]   pop;
    modport master (
        output req, req_len, flow_ok, multiple_ok, parked_on_us,
        input  int_req, multiple_in_progress, stream_break_point, int_requestor_piorqq,
               have_trans_waiting, piorqq_req, sel, beat_vld, beat_last, pop
    );
    modport slave (
        input  req, req_len, flow_ok, multiple_ok, parked_on_us,
        output int_req, multiple_in_progress, stream_break_point, int_requestor_piorqq,
               have_trans_waiting, piorqq_req, sel, beat_vld, beat_last, pop
    );
endinterface

// File: rtl/jbi_rr_pick4.sv
// jbi_rr_pick4: one-hot round-robin pick among 4 requesters, starting after last_winner
module jbi_rr_pick4 (
    input  logic [3:0] eligible_i,
    input  logic [1:0] last_winner_i,
    output logic [3:0] winner_o
);
    // scan from farthest to nearest so the nearest eligible after last_winner wins
    always_comb begin
        winner_o = '0;
        for (int k = 4; k >= 1; k--) begin
            if (eligible_i[last_winner_i + 2'(k)]) begin
                winner_o = '0;
                winner_o[last_winner_i + 2'(k)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/jbi_mout_sched.sv
// jbi_mout_sched: round-robin packet scheduler driving JBus requests and beat selection
module jbi_mout_sched
    import jbi_mout_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    jbi_mout_sched_if.slave  bus
);
    state_e           state_q, state_d;
    logic [1:0]       win_q, win_d, last_q, last_d, pick_last, pick_id;
    logic [2:0]       len_q, len_d, cnt_q, cnt_d;
    logic [N_REQ-1:0] elig, pick_oh;
    logic             act, last_beat;
    assign elig      = bus.req & bus.flow_ok;
    assign pick_last = state_q == ST_SEND ? win_q : last_q;
    assign pick_id   = oh2bin(pick_oh);
    assign last_beat = state_q == ST_SEND && cnt_q == len_q;
    assign act       = !rst;
    jbi_rr_pick4 u_pick (
        .eligible_i    (elig),
        .last_winner_i (pick_last),
        .winner_o      (pick_oh)
    );
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (|elig) begin
                state_d = ST_REQ;
                win_d   = pick_id;
                len_d   = bus.req_len[pick_id*3 +: 3];
            end
            ST_REQ: begin
                if (bus.multiple_ok) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end else if (!elig[win_q]) state_d = ST_IDLE;
            end
            ST_SEND: begin
                cnt_d = last_beat ? 3'd0 : cnt_q + 3'd1;
                if (last_beat) begin
                    last_d  = win_q;
                    // picking from win_q leaves the popped requester last in line
                    state_d = bus.parked_on_us && |elig ? ST_REQ : ST_IDLE;
                    win_d   = bus.parked_on_us && |elig ? pick_id : win_q;
                    len_d   = bus.parked_on_us && |elig ? bus.req_len[pick_id*3 +: 3] : len_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            last_q  <= 2'd3;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.int_req              = act && state_q != ST_IDLE;
    assign bus.beat_vld             = act && state_q == ST_SEND;
    assign bus.multiple_in_progress = bus.beat_vld;
    assign bus.beat_last            = act && last_beat;
    assign bus.stream_break_point   = bus.beat_last;
    assign bus.sel                  = bus.beat_vld ? 4'b0001 << win_q : 4'b0000;
    assign bus.pop                  = bus.beat_last ? 4'b0001 << win_q : 4'b0000;
    assign bus.int_requestor_piorqq = bus.int_req && win_q == REQ_PIORQQ;
    assign bus.have_trans_waiting   = |elig;
    assign bus.piorqq_req           = bus.req[0];
endmodule

// File: tb/tb_jbi_mout_sched.sv
// tb_jbi_mout_sched: directed and random stimulus against a packet-level scheduler model
module tb_jbi_mout_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    jbi_mout_sched_if bus();
    jbi_mout_sched dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0, n_err = 0;
    int m_phase = 0, m_win = 0, m_len = 0, m_sent = 0, m_last = 3, m_rcyc = 0;
    bit auto_mok = 0;
    int mok_dly = 0;
    int pops[$];
    int nvld = 0, nlast = 0, npio = 0;
    function automatic int rr(input logic [3:0] el, input int from);
        for (int k = 1; k <= 4; k++) if (el[(from + k) % 4]) return (from + k) % 4;
        return 0;
    endfunction
    function automatic int field(input logic [11:0] v, input int i);
        return int'(v >> (3 * i)) & 7;
    endfunction
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask
    task automatic step();
        logic [3:0] el;
        bit a, vld, lst;
        int s;
        if (auto_mok) bus.multiple_ok = (m_phase == 1 && m_rcyc >= mok_dly);
        #1;
        el  = bus.req & bus.flow_ok;
        a   = !rst;
        vld = a && m_phase == 2;
        lst = vld && m_sent == m_len;
        s   = vld ? (1 << m_win) : 0;
        chk("int_req", int'(bus.int_req), int'(a && m_phase != 0));
        chk("beat_vld", int'(bus.beat_vld), int'(vld));
        chk("mip", int'(bus.multiple_in_progress), int'(vld));
        chk("beat_last", int'(bus.beat_last), int'(lst));
        chk("sbp", int'(bus.stream_break_point), int'(lst));
        chk("sel", int'(bus.sel), s);
        chk("pop", int'(bus.pop), lst ? s : 0);
        chk("piorqq", int'(bus.int_requestor_piorqq), int'(a && m_phase != 0 && m_win == 0));
        chk("htw", int'(bus.have_trans_waiting), int'(el != 0));
        chk("piorqq_req", int'(bus.piorqq_req), int'(bus.req[0]));
        for (int i = 0; i < 4; i++) if (bus.pop[i]) pops.push_back(i);
        nvld  += int'(bus.beat_vld);
        nlast += int'(bus.beat_last);
        npio  += int'(bus.int_requestor_piorqq);
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_last = 3; m_sent = 0; m_rcyc = 0;
        end else if (m_phase == 0) begin
            if (el != 0) begin
                m_win = rr(el, m_last); m_len = field(bus.req_len, m_win); m_phase = 1; m_rcyc = 0;
            end
        end else if (m_phase == 1) begin
            if (bus.multiple_ok) begin
                m_phase = 2; m_sent = 0;
            end else if (!el[m_win]) m_phase = 0;
            else m_rcyc++;
        end else if (m_sent == m_len) begin
            m_last = m_win;
            if (bus.parked_on_us && el != 0) begin
                m_win = rr(el, m_win); m_len = field(bus.req_len, m_win); m_phase = 1; m_rcyc = 0;
            end else m_phase = 0;
        end else m_sent++;
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.flow_ok = 4'hF; bus.req_len = '0;
        bus.multiple_ok = 1'b0; bus.parked_on_us = 1'b0;
        step(); step();
        rst = 1'b0;
        pops.delete(); nvld = 0; nlast = 0; npio = 0;
    endtask
    initial begin
        int ord[4];
        int up, drops;
        bus.req = '0; bus.flow_ok = '0; bus.req_len = '0;
        bus.multiple_ok = 1'b0; bus.parked_on_us = 1'b0;
        @(negedge clk);
        // rotation between two requesters with single-beat packets
        do_reset();
        bus.req = 4'b0101; bus.parked_on_us = 1'b1; auto_mok = 1; mok_dly = 2;
        for (int i = 0; i < 60 && pops.size() < 4; i++) step();
        chk("n_pops_030", pops.size(), 4);
        ord = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) chk("order_030", i < pops.size() ? pops[i] : 99, ord[i]);
        chk("beats_030", nvld, 4);
        // maximum length packet
        do_reset();
        bus.req = 4'b0010; bus.req_len = 12'h038; auto_mok = 1; mok_dly = 0;
        for (int i = 0; i < 40 && nlast < 1; i++) step();
        chk("vld_031", nvld, 8);
        chk("last_031", nlast, 1);
        chk("popid_031", pops.size() > 0 ? pops[0] : 99, 1);
        // credit lost while requesting
        do_reset();
        bus.req = 4'b1000; auto_mok = 0;
        step(); step();
        chk("ireq_req_032", int'(bus.int_req), 1);
        bus.flow_ok = 4'h7;
        step();
        chk("ireq_032", int'(bus.int_req), 0);
        chk("pop_032", pops.size(), 0);
        // reset on third beat of a five-beat packet
        do_reset();
        bus.req = 4'b0100; bus.req_len = 12'h100; auto_mok = 1; mok_dly = 0;
        for (int i = 0; i < 30 && nvld < 2; i++) step();
        rst = 1'b1; bus.req = '0;
        step();
        rst = 1'b0;
        step();
        chk("ireq_033", int'(bus.int_req), 0);
        chk("vld_033", nvld, 2);
        chk("pop_033", pops.size(), 0);
        // all requesting, back-to-back while parked
        do_reset();
        bus.req = 4'hF; bus.parked_on_us = 1'b1; bus.req_len = 12'($urandom);
        auto_mok = 1; mok_dly = 1; up = 0; drops = 0;
        for (int i = 0; i < 120 && pops.size() < 4; i++) begin
            step();
            if (bus.int_req) up = 1;
            else if (up != 0 && pops.size() < 4) drops++;
        end
        chk("drops_034", drops, 0);
        ord = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) chk("order_034", i < pops.size() ? pops[i] : 99, ord[i]);
        // PIORQQ identification
        do_reset();
        bus.req = 4'b0001; bus.flow_ok = 4'h0; auto_mok = 1; mok_dly = 1;
        step();
        chk("htw_035", int'(bus.have_trans_waiting), 0);
        chk("preq_035", int'(bus.piorqq_req), 1);
        bus.flow_ok = 4'h1;
        for (int i = 0; i < 20 && pops.size() < 1; i++) step();
        bus.req = '0;
        chk("pio_cycles_035", npio, 3);
        // random traffic
        auto_mok = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) == 0);
            bus.req = 4'($urandom);
            bus.flow_ok = 4'($urandom | $urandom);
            bus.req_len = 12'($urandom);
            bus.multiple_ok = ($urandom_range(2) == 0);
            bus.parked_on_us = 1'($urandom);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
